// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and shift-amount width helper for the ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;

    function automatic int shamt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode inputs and registered result/flag outputs of the ALU.
interface alu_if #(
    parameter int bits = 16
);

    logic [bits-1:0] A;
    logic [bits-1:0] B;
    logic [bits-1:0] O;
    logic [bits-1:0] R;
    logic            Z;
    logic            C;
    logic            V;

    modport master (output A, B, O, input R, Z, C, V);
    modport slave  (input A, B, O, output R, Z, C, V);

endinterface

// File: rtl/alu_datapath.sv
// alu_datapath: combinational result and carry/overflow for one ALU operation.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int bits = 16
) (
    input  logic [bits-1:0] A,
    input  logic [bits-1:0] B,
    input  logic [3:0]      op,
    output logic [bits-1:0] res,
    output logic            c,
    output logic            v
);

    localparam int SW = shamt_width(bits);

    logic [bits:0]   w_sum;
    logic [bits:0]   w_dif;
    logic [SW-1:0]   w_sh;
    logic            w_add_v;
    logic            w_sub_v;
    logic            w_slt;

    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_dif   = {1'b0, A} - {1'b0, B};
    assign w_sh    = B[SW-1:0];
    assign w_add_v = (A[bits-1] == B[bits-1]) && (w_sum[bits-1] != A[bits-1]);
    assign w_sub_v = (A[bits-1] != B[bits-1]) && (w_dif[bits-1] != A[bits-1]);
    assign w_slt   = $signed(A) < $signed(B);

    // The extra top bit of w_dif is the unsigned borrow, shared by SUB and SLTU.
    always_comb begin
        res = '0;
        case (op)
            OP_ADD:   res = w_sum[bits-1:0];
            OP_SUB:   res = w_dif[bits-1:0];
            OP_AND:   res = A & B;
            OP_OR:    res = A | B;
            OP_XOR:   res = A ^ B;
            OP_NOR:   res = ~(A | B);
            OP_SLL:   res = A << w_sh;
            OP_SRL:   res = A >> w_sh;
            OP_SRA:   res = $unsigned($signed(A) >>> w_sh);
            OP_SLT:   res = {{(bits-1){1'b0}}, w_slt};
            OP_SLTU:  res = {{(bits-1){1'b0}}, w_dif[bits]};
            OP_PASSB: res = B;
            default:  res = '0;
        endcase
    end

    assign c = (op == OP_ADD) ? w_sum[bits] : (op == OP_SUB) ? w_dif[bits] : 1'b0;
    assign v = (op == OP_ADD) ? w_add_v : (op == OP_SUB) ? w_sub_v : 1'b0;

endmodule

// File: rtl/alu_unit.sv
// alu_unit: execute-stage ALU registering result and Z/C/V flags one cycle after issue.
module alu_unit
    import alu_pkg::*;
#(
    parameter int bits = 16
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [bits-1:0] w_res;
    logic            w_c;
    logic            w_v;
    logic [bits-1:0] r_res;
    logic            r_z;
    logic            r_c;
    logic            r_v;

    alu_datapath #(.bits(bits)) u_datapath (
        .A   (bus.A),
        .B   (bus.B),
        .op  (bus.O[3:0]),
        .res (w_res),
        .c   (w_c),
        .v   (w_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
            r_z   <= 1'b1;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
        end else begin
            r_res <= w_res;
            r_z   <= (w_res == '0);
            r_c   <= w_c;
            r_v   <= w_v;
        end
    end

    assign bus.R = r_res;
    assign bus.Z = r_z;
    assign bus.C = r_c;
    assign bus.V = r_v;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and random vectors, scoreboard queue checked one cycle after issue.
module tb_alu_unit;

    typedef struct {
        logic [15:0] r;
        logic        z;
        logic        c;
        logic        v;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    alu_if #(.bits(16)) bus ();

    alu_unit #(.bits(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic r_in, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] o, input logic [15:0] er, input logic ez,
                         input logic ec, input logic ev, input string nm);
        exp_t e;
        @(negedge clk);
        rst   = r_in;
        bus.A = a;
        bus.B = b;
        bus.O = o;
        e.r = er; e.z = ez; e.c = ec; e.v = ev; e.nm = nm;
        sb.push_back(e);
    endtask

    // Reference model written from the opcode definitions using signed integer ranges.
    task automatic issue_model(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
        int          sa, sb_i, s;
        logic [15:0] r;
        logic        c, v;
        sa   = int'($signed(a));
        sb_i = int'($signed(b));
        if (o[3:0] == 4'd0) begin
            s = sa + sb_i;
            r = a + b;
            c = (int'(a) + int'(b)) > 65535;
        end else begin
            s = sa - sb_i;
            r = a - b;
            c = a < b;
        end
        v = (s > 32767) || (s < -32768);
        issue(1'b0, a, b, o, r, r == 16'h0, c, v, (o[3:0] == 4'd0) ? "rand_add" : "rand_sub");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.R !== e.r || bus.Z !== e.z || bus.C !== e.c || bus.V !== e.v) begin
                    errors++;
                    $display("FAIL %s: got R=%h Z=%b C=%b V=%b, want R=%h Z=%b C=%b V=%b",
                             e.nm, bus.R, bus.Z, bus.C, bus.V, e.r, e.z, e.c, e.v);
                end
            end
        end
    end

    initial begin
        bus.A = '0;
        bus.B = '0;
        bus.O = '0;
        issue(1'b1, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "reset_0");
        issue(1'b1, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "reset_1");
        issue(1'b0, 16'h1234, 16'h0001, 16'h0000, 16'h1235, 1'b0, 1'b0, 1'b0, "post_reset");
        issue(1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, "add_ovf");
        issue(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "add_carry");
        issue(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "add_zero");
        issue(1'b0, 16'h0005, 16'h0007, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, "sub_borrow");
        issue(1'b0, 16'h8000, 16'h0001, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, "sub_minneg");
        issue(1'b0, 16'h0005, 16'h0007, 16'h0009, 16'h0001, 1'b0, 1'b0, 1'b0, "slt_pos");
        issue(1'b0, 16'hFFFF, 16'h0001, 16'h0009, 16'h0001, 1'b0, 1'b0, 1'b0, "slt_neg");
        issue(1'b0, 16'hFFFF, 16'h0001, 16'h000A, 16'h0000, 1'b1, 1'b0, 1'b0, "sltu");
        issue(1'b0, 16'hF0F0, 16'h0FF0, 16'h0002, 16'h00F0, 1'b0, 1'b0, 1'b0, "and");
        issue(1'b0, 16'hF0F0, 16'h0FF0, 16'h0003, 16'hFFF0, 1'b0, 1'b0, 1'b0, "or");
        issue(1'b0, 16'hF0F0, 16'h0FF0, 16'h0004, 16'hFF00, 1'b0, 1'b0, 1'b0, "xor");
        issue(1'b0, 16'hF0F0, 16'h0FF0, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, "nor");
        issue(1'b0, 16'h8001, 16'h0003, 16'h0008, 16'hF000, 1'b0, 1'b0, 1'b0, "sra");
        issue(1'b0, 16'h8001, 16'h0003, 16'h0007, 16'h1000, 1'b0, 1'b0, 1'b0, "srl");
        issue(1'b0, 16'h8001, 16'h0003, 16'h0006, 16'h0008, 1'b0, 1'b0, 1'b0, "sll");
        issue(1'b0, 16'h8001, 16'h0013, 16'h0008, 16'hF000, 1'b0, 1'b0, 1'b0, "sra_hi_b");
        issue(1'b0, 16'h8001, 16'h0013, 16'h0007, 16'h1000, 1'b0, 1'b0, 1'b0, "srl_hi_b");
        issue(1'b0, 16'h8001, 16'h0013, 16'h0006, 16'h0008, 1'b0, 1'b0, 1'b0, "sll_hi_b");
        issue(1'b0, 16'h1234, 16'h0010, 16'h0006, 16'h1234, 1'b0, 1'b0, 1'b0, "sll_zero");
        issue(1'b0, 16'h0001, 16'hABCD, 16'h000B, 16'hABCD, 1'b0, 1'b0, 1'b0, "passb");
        issue(1'b0, 16'h1234, 16'h0001, 16'h000C, 16'h0000, 1'b1, 1'b0, 1'b0, "reserved_c");
        issue(1'b0, 16'hFFFF, 16'hFFFF, 16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0, "reserved_f");
        issue(1'b0, 16'h0005, 16'h0007, 16'h0011, 16'hFFFE, 1'b0, 1'b1, 1'b0, "op_upper_ign");
        issue(1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, "pre_rst");
        issue(1'b1, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "mid_rst");
        for (int i = 0; i < 24; i++)
            issue_model(16'($urandom), 16'($urandom), (i % 2 == 0) ? 16'h0000 : 16'h0001);
        issue_model(16'h8000, 16'h8000, 16'h0000);
        issue_model(16'h7FFF, 16'hFFFF, 16'h0001);
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected results never checked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
